// File: rtl/axi_arb_pkg.sv
// Shared definitions for the AXI read-address arbiter.
//   arb_state_e : arbiter FSM states (ARB_IDLE, ARB_HOLD)
//   arb_id_w(n) : width of an encoded index into n masters, never below 1
//   ARB_MAX_MST : largest supported master count
package axi_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_HOLD = 1'b1
  } arb_state_e;

  localparam int unsigned ARB_MAX_MST = 16;

  function automatic int unsigned arb_id_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/axi_rd_rr_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req  : request vector (N bits)
//   ptr  : index of the highest-priority requester (W bits, < N)
//   pick : one-hot winner (all zero when req is zero)
//   idx  : encoded winner index
//   any  : at least one request present
module rr_pick #(
  parameter int unsigned N = 3,
  parameter int unsigned W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] pick,
  output logic [W-1:0] idx,
  output logic         any
);

  localparam logic [2*N-1:0] ONE = {{(2*N-1){1'b0}}, 1'b1};

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] masked;
  logic [2*N-1:0] first;

  // Requests are duplicated so that clearing everything below ptr still
  // leaves the wrapped-around requesters visible in the upper copy; the
  // lowest surviving bit is then the round-robin winner.
  assign dbl    = {req, req};
  assign masked = dbl & ~((ONE << ptr) - ONE);
  assign first  = masked & ~(masked - ONE);
  assign pick   = first[N-1:0] | first[2*N-1:N];
  assign any    = |req;

  always_comb begin
    idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (pick[i]) idx = W'(i);
    end
  end

endmodule

// File: rtl/axi_rd_rr_arbiter.sv
// Round-robin arbiter for the interconnect read-address path.
// A winner is granted from ARB_IDLE and held in ARB_HOLD until rd_done;
// priority then rotates to the master after the last winner.
// Optional feature macro: ARB_QOS_EN adds rd_urgent; urgent requesters
// are arbitrated ahead of the rest.
//   sys_clk      : clock, rising edge
//   sys_rst      : asynchronous active-high reset
//   rd_req       : per-master read request (level)
//   rd_urgent    : per-master QoS urgent flag (ARB_QOS_EN only)
//   rd_done      : pulse, granted transaction complete
//   rd_grant     : registered one-hot grant
//   rd_grant_id  : encoded index of the granted master
//   rd_grant_vld : a grant is held
module axi_rd_rr_arbiter
  import axi_arb_pkg::*;
#(
  parameter int unsigned NUM_MST = 3,
  parameter int unsigned ID_W    = arb_id_w(NUM_MST)
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic [NUM_MST-1:0] rd_req,
`ifdef ARB_QOS_EN
  input  logic [NUM_MST-1:0] rd_urgent,
`endif
  input  logic               rd_done,
  output logic [NUM_MST-1:0] rd_grant,
  output logic [ID_W-1:0]    rd_grant_id,
  output logic               rd_grant_vld
);

  if (NUM_MST < 1 || NUM_MST > ARB_MAX_MST) begin : g_bad_num_mst
    $error("axi_rd_rr_arbiter: NUM_MST out of range");
  end

  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_MST - 1);

  arb_state_e        state_q, state_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic [NUM_MST-1:0] grant_d;
  logic [ID_W-1:0]   id_d;
  logic [NUM_MST-1:0] cand;
  logic [NUM_MST-1:0] pick;
  logic [ID_W-1:0]   pick_idx;
  logic              pick_any;

`ifdef ARB_QOS_EN
  logic [NUM_MST-1:0] urgent_req;
  assign urgent_req = rd_req & rd_urgent;
  assign cand       = (|urgent_req) ? urgent_req : rd_req;
`else
  assign cand = rd_req;
`endif

  rr_pick #(
    .N (NUM_MST),
    .W (ID_W)
  ) u_pick (
    .req  (cand),
    .ptr  (ptr_q),
    .pick (pick),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= ARB_IDLE;
      ptr_q       <= '0;
      rd_grant    <= '0;
      rd_grant_id <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rd_grant    <= grant_d;
      rd_grant_id <= id_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE: if (pick_any) state_d = ARB_HOLD;
      ARB_HOLD: if (rd_done)  state_d = ARB_IDLE;
      default:                state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    grant_d = rd_grant;
    id_d    = rd_grant_id;
    ptr_d   = ptr_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          grant_d = pick;
          id_d    = pick_idx;
        end
      end
      ARB_HOLD: begin
        if (rd_done) begin
          grant_d = '0;
          id_d    = '0;
          ptr_d   = (rd_grant_id == LAST_ID) ? '0 : rd_grant_id + ID_W'(1);
        end
      end
      default: begin
        grant_d = '0;
        id_d    = '0;
      end
    endcase
  end

  // Derived from the state register, so it moves on the same edges as the
  // grant registers.
  assign rd_grant_vld = (state_q == ARB_HOLD);

endmodule
